// File: rtl/sdram_page_scheduler.sv
// sdram_page_scheduler
// Arbitrates whole-page writes (upstream FIFO -> SDRAM) and whole-page reads
// (SDRAM -> downstream sink) over a ring of DEPTH pages held in SDRAM.
// Tracks write/read page pointers and the fill level, runs a request/ack/done
// handshake with the SDRAM controller and aborts operations that hang.
module sdram_page_scheduler #(
  parameter int PAGE_AW    = 15,
  parameter int HIGH_WATER = (1 << PAGE_AW) - 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               rfo,
  input  logic               fifo_tx_rdy,
  input  logic               sink_rdy,
  input  logic               op_ack,
  input  logic               op_done,
  input  logic               err_clr,
  output logic               wr_req,
  output logic               rd_req,
  output logic [PAGE_AW-1:0] page_addr,
  output logic [PAGE_AW:0]   fill,
  output logic               full,
  output logic               empty,
  output logic               err_timeout
);

  // Timer holds 0..TIMEOUT-1; the abort fires on the cycle it would reach TIMEOUT.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [TW-1:0]      C_TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]      C_TMR_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]      C_TMR_ONE  = TW'(1);
  localparam logic [PAGE_AW:0]   C_DEPTH    = {1'b1, {PAGE_AW{1'b0}}};
  localparam logic [PAGE_AW:0]   C_HIGH     = (PAGE_AW + 1)'(HIGH_WATER);
  localparam logic [PAGE_AW:0]   C_FILL_0   = {(PAGE_AW + 1){1'b0}};
  localparam logic [PAGE_AW:0]   C_FILL_1   = (PAGE_AW + 1)'(1);
  localparam logic [PAGE_AW-1:0] C_PTR_0    = {PAGE_AW{1'b0}};
  localparam logic [PAGE_AW-1:0] C_PTR_1    = PAGE_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_wr_req;
  logic               r_rd_req;
  logic [PAGE_AW-1:0] r_page_addr;
  logic [PAGE_AW-1:0] r_wr_ptr;
  logic [PAGE_AW-1:0] r_rd_ptr;
  logic [PAGE_AW:0]   r_fill;
  logic               r_full;
  logic               r_empty;
  logic               r_err;
  logic [TW-1:0]      r_timer;
  logic               r_last_wr;

  logic               w_wr_req_nxt;
  logic               w_rd_req_nxt;
  logic [PAGE_AW-1:0] w_page_addr_nxt;
  logic [PAGE_AW-1:0] w_wr_ptr_nxt;
  logic [PAGE_AW-1:0] w_rd_ptr_nxt;
  logic [PAGE_AW:0]   w_fill_nxt;
  logic               w_full_nxt;
  logic               w_empty_nxt;
  logic               w_err_nxt;
  logic [TW-1:0]      w_timer_nxt;
  logic               w_last_wr_nxt;

  logic w_wr_elig;
  logic w_rd_elig;
  logic w_pick_rd;
  logic w_tmo;
  logic w_wr_fin;
  logic w_rd_fin;
  logic w_abort;

  // Eligibility uses the registered full/empty flags so a grant never
  // depends on a fill update happening in the same cycle.
  assign w_wr_elig = fifo_tx_rdy & ~r_full;
  assign w_rd_elig = sink_rdy & ~r_empty;
  assign w_tmo     = (r_timer == C_TMO_LAST);

  // Contest resolution: near-full ring drains first, otherwise alternate.
  always_comb begin
    w_pick_rd = 1'b0;
    if (w_wr_elig && w_rd_elig) begin
      w_pick_rd = (r_fill >= C_HIGH) | r_last_wr;
    end else begin
      w_pick_rd = w_rd_elig;
    end
  end

  // Next-state and next-output logic for the request/ack/done handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_req_nxt    = r_wr_req;
    w_rd_req_nxt    = r_rd_req;
    w_page_addr_nxt = r_page_addr;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_fill_nxt      = r_fill;
    w_timer_nxt     = r_timer;
    w_last_wr_nxt   = r_last_wr;
    w_wr_fin        = 1'b0;
    w_rd_fin        = 1'b0;
    w_abort         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rfo && (w_wr_elig || w_rd_elig)) begin
          w_timer_nxt = C_TMR_ZERO;
          if (w_pick_rd) begin
            w_state_nxt     = S_RD_REQ;
            w_rd_req_nxt    = 1'b1;
            w_page_addr_nxt = r_rd_ptr;
            w_last_wr_nxt   = 1'b0;
          end else begin
            w_state_nxt     = S_WR_REQ;
            w_wr_req_nxt    = 1'b1;
            w_page_addr_nxt = r_wr_ptr;
            w_last_wr_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_REQ: begin
        if (op_ack && op_done) begin
          w_wr_fin = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end else if (op_ack) begin
          w_wr_req_nxt = 1'b0;
          w_state_nxt  = S_WR_WAIT;
          w_timer_nxt  = r_timer + C_TMR_ONE;
        end else begin
          w_timer_nxt = r_timer + C_TMR_ONE;
        end
      end
      S_WR_WAIT: begin
        if (op_done) begin
          w_wr_fin = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end else begin
          w_timer_nxt = r_timer + C_TMR_ONE;
        end
      end
      S_RD_REQ: begin
        if (op_ack && op_done) begin
          w_rd_fin = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end else if (op_ack) begin
          w_rd_req_nxt = 1'b0;
          w_state_nxt  = S_RD_WAIT;
          w_timer_nxt  = r_timer + C_TMR_ONE;
        end else begin
          w_timer_nxt = r_timer + C_TMR_ONE;
        end
      end
      S_RD_WAIT: begin
        if (op_done) begin
          w_rd_fin = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end else begin
          w_timer_nxt = r_timer + C_TMR_ONE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_wr_req_nxt = 1'b0;
        w_rd_req_nxt = 1'b0;
      end
    endcase

    // Completed pages advance their pointer; an abort leaves ring state alone.
    if (w_wr_fin) begin
      w_wr_ptr_nxt = r_wr_ptr + C_PTR_1;
      w_fill_nxt   = r_fill + C_FILL_1;
    end else if (w_rd_fin) begin
      w_rd_ptr_nxt = r_rd_ptr + C_PTR_1;
      w_fill_nxt   = r_fill - C_FILL_1;
    end else begin
      w_fill_nxt = r_fill;
    end

    if (w_wr_fin || w_rd_fin || w_abort) begin
      w_state_nxt  = S_IDLE;
      w_wr_req_nxt = 1'b0;
      w_rd_req_nxt = 1'b0;
    end else begin
      w_timer_nxt = w_timer_nxt;
    end
  end

  // Flags are computed from the next fill so they update with fill itself.
  assign w_full_nxt  = (w_fill_nxt == C_DEPTH);
  assign w_empty_nxt = (w_fill_nxt == C_FILL_0);
  // A timeout in the same cycle as err_clr keeps the flag set.
  assign w_err_nxt   = w_abort | (r_err & ~err_clr);

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, ring pointers, fill, timer and arbitration history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_page_addr <= C_PTR_0;
      r_wr_ptr    <= C_PTR_0;
      r_rd_ptr    <= C_PTR_0;
      r_fill      <= C_FILL_0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_err       <= 1'b0;
      r_timer     <= C_TMR_ZERO;
      r_last_wr   <= 1'b0;
    end else begin
      r_wr_req    <= w_wr_req_nxt;
      r_rd_req    <= w_rd_req_nxt;
      r_page_addr <= w_page_addr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_fill      <= w_fill_nxt;
      r_full      <= w_full_nxt;
      r_empty     <= w_empty_nxt;
      r_err       <= w_err_nxt;
      r_timer     <= w_timer_nxt;
      r_last_wr   <= w_last_wr_nxt;
    end
  end

  assign wr_req      = r_wr_req;
  assign rd_req      = r_rd_req;
  assign page_addr   = r_page_addr;
  assign fill        = r_fill;
  assign full        = r_full;
  assign empty       = r_empty;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_sdram_page_scheduler.sv
// Bench for sdram_page_scheduler: directed scenarios plus randomized traffic,
// with a transaction-level reference model compared every cycle.
module tb_sdram_page_scheduler;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int HW    = 12;
  localparam int TMO   = 600;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          rfo, fifo_tx_rdy, sink_rdy, op_ack, op_done, err_clr;
  logic          wr_req, rd_req, full, empty, err_timeout;
  logic [AW-1:0] page_addr;
  logic [AW:0]   fill;

  sdram_page_scheduler #(.PAGE_AW(AW), .HIGH_WATER(HW), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .rfo(rfo), .fifo_tx_rdy(fifo_tx_rdy),
    .sink_rdy(sink_rdy), .op_ack(op_ack), .op_done(op_done), .err_clr(err_clr),
    .wr_req(wr_req), .rd_req(rd_req), .page_addr(page_addr), .fill(fill),
    .full(full), .empty(empty), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit m_busy, m_rd, m_acked, m_last_rd, m_err;
  int m_age, m_fill, m_wp, m_rp, m_addr;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 0; m_rd = 0; m_acked = 0; m_last_rd = 1; m_err = 0;
      m_age = 0; m_fill = 0; m_wp = 0; m_rp = 0; m_addr = 0;
    end else begin
      bit set_e, wel, rel;
      set_e = 0;
      if (!m_busy) begin
        wel = fifo_tx_rdy && (m_fill < DEPTH);
        rel = sink_rdy && (m_fill > 0);
        if (rfo && (wel || rel)) begin
          m_rd      = (wel && rel) ? ((m_fill >= HW) || !m_last_rd) : rel;
          m_busy    = 1;
          m_acked   = 0;
          m_age     = 0;
          m_addr    = m_rd ? m_rp : m_wp;
          m_last_rd = m_rd;
        end
      end else begin
        m_age++;
        if (op_done && (m_acked || op_ack)) begin
          m_busy = 0;
          if (m_rd) begin m_rp = (m_rp + 1) % DEPTH; m_fill--; end
          else begin m_wp = (m_wp + 1) % DEPTH; m_fill++; end
        end else if (m_age == TMO) begin
          m_busy = 0;
          set_e  = 1;
        end else if (op_ack) begin
          m_acked = 1;
        end
      end
      m_err = set_e ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      chk("wr_req", int'(wr_req), int'(m_busy && !m_rd && !m_acked));
      chk("rd_req", int'(rd_req), int'(m_busy && m_rd && !m_acked));
      chk("page_addr", int'(page_addr), m_addr);
      chk("fill", int'(fill), m_fill);
      chk("full", int'(full), int'(m_fill == DEPTH));
      chk("empty", int'(empty), int'(m_fill == 0));
      chk("err_timeout", int'(err_timeout), int'(m_err));
    end
  end

  // ---------------- controller responder and grant log ----------------
  int ctl_phase = 0, ctl_cnt = 0, ack_dly = 1, done_dly = 2, cyc_n = 0;
  bit withhold = 0, noise = 0, rand_dly = 0, prev_wr = 0, prev_rd = 0;
  int g_rd[$];
  int g_addr[$];

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (wr_req && !prev_wr) begin g_rd.push_back(0); g_addr.push_back(int'(page_addr)); end
    if (rd_req && !prev_rd) begin g_rd.push_back(1); g_addr.push_back(int'(page_addr)); end
    prev_wr = wr_req;
    prev_rd = rd_req;
    op_ack  = 1'b0;
    op_done = 1'b0;
    if (ctl_phase == 0 && (wr_req || rd_req)) begin
      ctl_phase = 1;
      ctl_cnt   = 0;
      if (rand_dly) begin
        ack_dly  = $urandom_range(1, 4);
        done_dly = $urandom_range(0, 6);
      end
    end
    if (ctl_phase == 1) begin
      ctl_cnt++;
      if (ctl_cnt >= ack_dly) begin
        op_ack = 1'b1;
        if (done_dly == 0 && !withhold) begin op_done = 1'b1; ctl_phase = 0; end
        else begin ctl_phase = 2; ctl_cnt = 0; end
      end else if (noise) begin
        op_done = ($urandom_range(0, 7) == 0);
      end
    end else if (ctl_phase == 2) begin
      ctl_cnt++;
      if (ctl_cnt >= done_dly && !withhold) begin op_done = 1'b1; ctl_phase = 0; end
      else if (noise) op_ack = ($urandom_range(0, 3) == 0);
    end else if (noise) begin
      op_ack  = ($urandom_range(0, 7) == 0);
      op_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic wait_fill(input int tgt, input int budget, input string nm);
    int n = 0;
    while (int'(fill) != tgt && n < budget) begin cyc(); n++; end
    chk(nm, int'(fill), tgt);
  endtask

  task automatic wait_grants(input int cnt, input int budget, input string nm);
    int n = 0;
    while (g_rd.size() < cnt && n < budget) begin cyc(); n++; end
    chk(nm, g_rd.size(), cnt);
  endtask

  task automatic settle(input int budget);
    int n = 0;
    while ((ctl_phase != 0 || wr_req || rd_req) && n < budget) begin cyc(); n++; end
    chk("settle_idle", int'(ctl_phase != 0 || wr_req || rd_req), 0);
    repeat (2) cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt, t0, n;
    n_rst = 1'b0; rfo = 1'b0; fifo_tx_rdy = 1'b0; sink_rdy = 1'b0;
    op_ack = 1'b0; op_done = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_page_addr", int'(page_addr), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_err", int'(err_timeout), 0);
    n_rst = 1'b1;
    cyc();

    // Single write: ack two cycles into the request, done 520 cycles later.
    rfo = 1'b1; fifo_tx_rdy = 1'b1; ack_dly = 2; done_dly = 520;
    wr_cnt = 0; n = 0;
    while (int'(fill) != 1 && n < 700) begin
      cyc(); n++;
      if (wr_req) wr_cnt++;
    end
    fifo_tx_rdy = 1'b0;
    chk("first_wr_held", wr_cnt, 2);
    chk("first_wr_addr", int'(page_addr), 0);
    chk("first_wr_fill", int'(fill), 1);
    chk("first_wr_empty", int'(empty), 0);
    ack_dly = 1; done_dly = 2;

    // Fill to 3, then 8 contested ops alternate starting with a read.
    fifo_tx_rdy = 1'b1;
    wait_fill(3, 100, "prefill3");
    fifo_tx_rdy = 1'b0;
    settle(50);
    g_rd.delete(); g_addr.delete();
    fifo_tx_rdy = 1'b1; sink_rdy = 1'b1;
    wait_grants(8, 300, "alt_grants");
    fifo_tx_rdy = 1'b0; sink_rdy = 1'b0;
    settle(50);
    for (int i = 0; i < 8 && i < g_rd.size(); i++)
      chk($sformatf("alt_kind%0d", i), g_rd[i], (i % 2 == 0) ? 1 : 0);
    chk("alt_fill", int'(fill), 3);
    chk("model_alt_fill", m_fill, 3);

    // Fill the ring; no further writes are requested while full.
    fifo_tx_rdy = 1'b1;
    wait_fill(DEPTH, 400, "fill_to_full");
    chk("full_flag", int'(full), 1);
    g_rd.delete(); g_addr.delete();
    repeat (20) cyc();
    chk("no_wr_when_full", g_rd.size(), 0);
    fifo_tx_rdy = 1'b0; sink_rdy = 1'b1;
    wait_grants(1, 20, "one_read");
    sink_rdy = 1'b0;
    settle(50);
    chk("after_read_full", int'(full), 0);
    chk("after_read_fill", int'(fill), DEPTH - 1);

    // Above high water reads win every contest; wr_ptr has wrapped to 4.
    g_rd.delete(); g_addr.delete();
    fifo_tx_rdy = 1'b1; sink_rdy = 1'b1;
    wait_grants(5, 300, "hw_grants");
    fifo_tx_rdy = 1'b0; sink_rdy = 1'b0;
    settle(50);
    for (int i = 0; i < 5 && i < g_rd.size(); i++) begin
      chk($sformatf("hw_kind%0d", i), g_rd[i], (i < 4) ? 1 : 0);
      chk($sformatf("hw_addr%0d", i), g_addr[i], (i < 4) ? (5 + i) : 4);
    end
    chk("hw_fill", int'(fill), 12);

    // Timeout: ack given, done withheld.
    g_rd.delete(); g_addr.delete();
    withhold = 1'b1; fifo_tx_rdy = 1'b1;
    wait_grants(1, 20, "tmo_grant");
    fifo_tx_rdy = 1'b0;
    t0 = cyc_n; n = 0;
    while (!err_timeout && n < TMO + 50) begin cyc(); n++; end
    chk("tmo_latency", cyc_n - t0, TMO);
    chk("tmo_err", int'(err_timeout), 1);
    chk("tmo_fill", int'(fill), 12);
    chk("tmo_wr_req", int'(wr_req), 0);
    withhold = 1'b0; ctl_phase = 0;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_cleared", int'(err_timeout), 0);

    // Reset during WR_WAIT abandons the write; a late op_done is ignored.
    g_rd.delete(); g_addr.delete();
    done_dly = 300; fifo_tx_rdy = 1'b1;
    wait_grants(1, 20, "rst_op_grant");
    fifo_tx_rdy = 1'b0;
    n = 0;
    while ((ctl_phase != 2 || wr_req) && n < 10) begin cyc(); n++; end
    repeat (5) cyc();
    chk("pre_rst_fill", int'(fill), 12);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_wr_req", int'(wr_req), 0);
    chk("mid_rst_fill", int'(fill), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_addr", int'(page_addr), 0);
    @(negedge clk);
    n_rst = 1'b1; ctl_phase = 0; done_dly = 2;
    cyc();
    op_done = 1'b1;
    cyc();
    cyc();
    chk("late_done_fill", int'(fill), 0);
    chk("late_done_empty", int'(empty), 1);

    // Randomized traffic with spurious pulses and rfo drops.
    rand_dly = 1'b1; noise = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      rfo         = ($urandom_range(0, 9) != 0);
      fifo_tx_rdy = $urandom_range(0, 1);
      sink_rdy    = $urandom_range(0, 1);
      err_clr     = ($urandom_range(0, 19) == 0);
    end
    noise = 1'b0; fifo_tx_rdy = 1'b0; sink_rdy = 1'b0; err_clr = 1'b0;
    settle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
